// File: rtl/viewport_pkg.sv
// Shared viewport defaults and generator state encoding.
// Pure declarations: no logic, no latency, no flow control.
package viewport_pkg;
  localparam int H_RES_DFLT   = 640;
  localparam int V_RES_DFLT   = 480;
  localparam int COORD_W_DFLT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/viewport_coord_gen_axis_stepper.sv
// One axis: wrapping position counter plus add/sub coordinate accumulator.
// Latency 1 cycle from start/advance; holds state whenever advance is low.
module axis_stepper
  import viewport_pkg::*;
#(
  parameter int COUNT    = H_RES_DFLT,
  parameter int COORD_W  = COORD_W_DFLT,
  parameter bit SUBTRACT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic [COORD_W-1:0] origin,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] coord,
  output logic               at_start,
  output logic               last
);
  localparam int PW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [PW-1:0]      pos;
  logic [COORD_W-1:0] base;
  logic [COORD_W-1:0] step_q;
  logic [COORD_W-1:0] coord_nxt;

  assign at_start  = (pos == '0);
  assign last      = (pos == PW'(COUNT - 1));
  // Modular add/sub: wrap-around is the intended two's complement behaviour.
  assign coord_nxt = SUBTRACT ? (coord - step_q) : (coord + step_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos    <= '0;
      coord  <= '0;
      base   <= '0;
      step_q <= '0;
    end else if (start) begin
      pos    <= '0;
      coord  <= origin;
      base   <= origin;
      step_q <= step;
    end else if (advance) begin
      if (last) begin
        pos   <= '0;
        coord <= base;
      end else begin
        pos   <= pos + PW'(1);
        coord <= coord_nxt;
      end
    end
  end
endmodule

// File: rtl/viewport_coord_gen.sv
// Raster-scan complex-plane coordinate generator with per-frame config latch.
// First pixel 1 cycle after enable; outputs held stable while ready is low.
module viewport_coord_gen
  import viewport_pkg::*;
#(
  parameter int H_RES   = H_RES_DFLT,
  parameter int V_RES   = V_RES_DFLT,
  parameter int COORD_W = COORD_W_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_enable,
  input  logic signed [COORD_W-1:0] cfg_origin_re,
  input  logic signed [COORD_W-1:0] cfg_origin_im,
  input  logic        [COORD_W-1:0] cfg_step,
  input  logic                      ready,
  output logic                      valid,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      first,
  output logic                      lastx,
  output logic                      lasty
);
  state_t state;
  logic   xfer;
  logic   frame_end;
  logic   start;
  logic   x_start, x_last;
  logic   y_start, y_last;

  assign valid     = (state == RUN);
  assign xfer      = valid & ready;
  assign frame_end = xfer & x_last & y_last;
  // Config is latched only when a frame begins, so mid-frame changes wait.
  assign start     = cfg_enable & ((state == IDLE) | frame_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_enable) state <= RUN;
        RUN:     if (frame_end && !cfg_enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  axis_stepper #(
    .COUNT    (H_RES),
    .COORD_W  (COORD_W),
    .SUBTRACT (1'b0)
  ) u_x_axis (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .advance  (xfer),
    .origin   (cfg_origin_re),
    .step     (cfg_step),
    .coord    (x),
    .at_start (x_start),
    .last     (x_last)
  );

  // Imaginary axis descends one step per line.
  axis_stepper #(
    .COUNT    (V_RES),
    .COORD_W  (COORD_W),
    .SUBTRACT (1'b1)
  ) u_y_axis (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .advance  (xfer & x_last),
    .origin   (cfg_origin_im),
    .step     (cfg_step),
    .coord    (y),
    .at_start (y_start),
    .last     (y_last)
  );

  assign first = valid & x_start & y_start;
  assign lastx = valid & x_last;
  assign lasty = valid & y_last;
endmodule

// File: doc/viewport_coord_gen.md
VIEWPORT_COORD_GEN -- requirements
Module: viewport_coord_gen

Interface
REQ-001 Parameter H_RES, default 640, pixels per line.
REQ-002 Parameter V_RES, default 480, lines per frame.
REQ-003 Parameter COORD_W, default 16, width of signed coordinate and config words.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_enable  input  1  generation enable, sampled only at frame boundaries.
REQ-007 cfg_origin_re  input  COORD_W  signed real coordinate of top-left pixel.
REQ-008 cfg_origin_im  input  COORD_W  signed imaginary coordinate of top-left pixel.
REQ-009 cfg_step  input  COORD_W  unsigned per-pixel increment, same LSB scale as the coordinates.
REQ-010 ready  input  1  downstream accepts the current pixel.
REQ-011 valid  output  1  x/y/flags hold a pixel.
REQ-012 x  output  COORD_W  signed real coordinate.
REQ-013 y  output  COORD_W  signed imaginary coordinate.
REQ-014 first  output  1  pixel (0,0) of a frame; drives downstream start-of-frame and register latching.
REQ-015 lastx  output  1  last pixel of a line.
REQ-016 lasty  output  1  pixel on the last line.

Function
REQ-017 A transfer occurs on a cycle with valid=1 and ready=1; no other condition advances the pixel.
REQ-018 While valid=1 and ready=0, x, y, first, lastx and lasty remain stable.
REQ-019 States: IDLE (valid=0) and RUN (valid=1).
REQ-020 IDLE with cfg_enable=1 shall latch all cfg_* inputs, enter RUN and present pixel (0,0) on the next cycle.
REQ-021 IDLE with cfg_enable=0 shall remain in IDLE.
REQ-022 Pixel (col,row) shall carry x = origin_re + col*step and y = origin_im - row*step, using the latched config.
REQ-023 x and y shall be formed incrementally with adders, not multipliers.
REQ-024 Coordinate arithmetic wraps modulo 2^COORD_W (two's complement) and never saturates.
REQ-025 first=1 iff col=0 and row=0.
REQ-026 lastx=1 iff col=H_RES-1.
REQ-027 lasty=1 iff row=V_RES-1.
REQ-028 On a transfer with lastx=0, the next pixel is col+1 and x advances by step.
REQ-029 On a transfer with lastx=1 and lasty=0, the next pixel is col=0, row+1, with x reloaded to origin_re and y reduced by step.
REQ-030 On a transfer with lastx=1 and lasty=1 and cfg_enable=1, the block shall latch the config in that cycle and present pixel (0,0) of the next frame on the next cycle, with no bubble.
REQ-031 On a transfer with lastx=1 and lasty=1 and cfg_enable=0, the next cycle shall enter IDLE.
REQ-032 cfg_* changes during a frame shall have no effect until the next frame-boundary latch.
REQ-033 cfg_step=0 is legal and yields constant coordinates; the counters still advance.

Reset
REQ-034 reset=1 shall force IDLE, valid=0, first=lastx=lasty=0, x=y=0 and col=row=0 on the next edge, overriding any transfer in that cycle.
REQ-035 Reset asserted mid-frame shall abandon the frame; after release, generation restarts at pixel (0,0) with first=1.

Structure
REQ-036 A shared package viewport_pkg holds the H_RES/V_RES defaults, COORD_W and the IDLE/RUN state enum.
REQ-037 One sub-module, axis_stepper, shall implement a wrapping position counter plus coordinate accumulator and be instantiated once per axis.

Verification (H_RES=4, V_RES=3)
REQ-038 Scenario: origin (-100,50), step 10, ready=1 -> x sequence -100,-90,-80,-70 repeating; y = 50,40,30 per line; first only on pixel 0; lasty+lastx together on the 12th pixel.
REQ-039 Scenario: ready=0 for 3 cycles while pixel 2 is presented -> x=-80 and the flags are held, and the sequence then resumes at -70.
REQ-040 Scenario: origin_re changed to 0 at pixel 5 -> the current frame is unchanged, and the next frame starts at x=0 with no idle cycle between frames.
REQ-041 Scenario: origin_re 32760, step 5 -> x = 32760, 32765, -32766, -32761.
REQ-042 Scenario: reset pulsed at pixel 7 -> valid=0 the next cycle, and the first pixel after release is (0,0) with first=1 and x=origin_re.
REQ-043 Scenario: cfg_enable dropped mid-frame -> the frame completes, valid=0 the cycle after the 12th transfer, and generation resumes one cycle after cfg_enable returns to 1.
